// File: rtl/rot_ctrl.sv
// rot_ctrl: raster-scan sequencer for the image-rotation core; one DMA read and one remapped
// DMA write per pixel. Optional handshake watchdog enabled by defining ROTCTRL_TIMEOUT_EN.
module rot_ctrl #(
  parameter int PIX_SHIFT   = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        I_ROTCTRL_HCLK,
  input  logic        I_ROTCTRL_HRESET,
  input  logic [31:0] I_ROTCTRL_SRC_IMG,
  input  logic [31:0] I_ROTCTRL_DST_IMG,
  input  logic [15:0] I_ROTCTRL_IMG_H,
  input  logic [15:0] I_ROTCTRL_IMG_W,
  input  logic [1:0]  I_ROTCTRL_IMG_MODE,
  input  logic        I_ROTCTRL_IMG_DIR,
  input  logic        I_ROTCTRL_START,
  input  logic        I_ROTCTRL_SOFT_RESET,
  input  logic        I_ROTCTRL_INTR_MASK,
  input  logic        I_ROTCTRL_INTR_CLEAR,
  output logic        O_ROTCTRL_RD_REQ,
  output logic [31:0] O_ROTCTRL_RD_ADDR,
  input  logic        I_ROTCTRL_RD_ACK,
  input  logic [31:0] I_ROTCTRL_RD_DATA,
  output logic        O_ROTCTRL_WR_REQ,
  output logic [31:0] O_ROTCTRL_WR_ADDR,
  output logic [31:0] O_ROTCTRL_WR_DATA,
  input  logic        I_ROTCTRL_WR_ACK,
  output logic [15:0] O_ROTCTRL_NEW_H,
  output logic [15:0] O_ROTCTRL_NEW_W,
  output logic        O_ROTCTRL_BUSY,
  output logic        O_ROTCTRL_DONE,
  output logic        O_ROTCTRL_INTR,
  output logic        O_ROTCTRL_ERR,
  output logic [1:0]  O_ROTCTRL_DBG_STATE
);

  // Handshake: a REQ rises together with a stable address (and data for writes) and stays
  // high until its ACK is sampled high at a clock edge; that edge completes the transfer.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state;
  logic        start_q;
  logic        done_flag;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] cfg_w;
  logic [15:0] cfg_h;
  logic [31:0] cfg_src;
  logic [31:0] cfg_dst;
  logic [1:0]  cfg_rot;

  logic [1:0]  rot_in;
  logic        start_edge;
  logic        start_accept;
  logic        empty_img;
  logic        x_last;
  logic        last_pix;
  logic        done_set;
  logic        wd_fire;
  logic [15:0] nx;
  logic [15:0] ny;

  function automatic logic [31:0] src_index(input logic [15:0] fx, input logic [15:0] fy,
                                            input logic [15:0] fw);
    src_index = 32'(fy) * 32'(fw) + 32'(fx);
  endfunction

  function automatic logic [31:0] dst_index(input logic [15:0] fx, input logic [15:0] fy,
                                            input logic [15:0] fw, input logic [15:0] fh,
                                            input logic [1:0]  fr);
    logic [31:0] xr;
    logic [31:0] yr;
    logic [31:0] idx;
    xr = 32'(fw) - 32'd1 - 32'(fx);
    yr = 32'(fh) - 32'd1 - 32'(fy);
    case (fr)
      2'd0:    idx = 32'(fy) * 32'(fw) + 32'(fx);
      2'd1:    idx = 32'(fx) * 32'(fh) + yr;
      2'd2:    idx = yr * 32'(fw) + xr;
      default: idx = xr * 32'(fh) + 32'(fy);
    endcase
    dst_index = idx;
  endfunction

  function automatic logic [31:0] pix_addr(input logic [31:0] base, input logic [31:0] idx);
    pix_addr = base + (idx << PIX_SHIFT);
  endfunction

  // Counter-clockwise by k quarter turns equals clockwise by (4-k) mod 4.
  assign rot_in = I_ROTCTRL_IMG_DIR ? (2'd0 - I_ROTCTRL_IMG_MODE) : I_ROTCTRL_IMG_MODE;

  assign O_ROTCTRL_NEW_W = rot_in[0] ? I_ROTCTRL_IMG_H : I_ROTCTRL_IMG_W;
  assign O_ROTCTRL_NEW_H = rot_in[0] ? I_ROTCTRL_IMG_W : I_ROTCTRL_IMG_H;

  assign start_edge   = I_ROTCTRL_START & ~start_q;
  assign start_accept = (state == S_IDLE) & start_edge;
  assign empty_img    = (I_ROTCTRL_IMG_H == 16'd0) | (I_ROTCTRL_IMG_W == 16'd0);
  assign x_last       = (x == cfg_w - 16'd1);
  assign last_pix     = x_last & (y == cfg_h - 16'd1);
  assign nx           = x_last ? 16'd0 : x + 16'd1;
  assign ny           = x_last ? y + 16'd1 : y;

  assign done_set = (start_accept & empty_img)
                  | ((state == S_WR) & O_ROTCTRL_WR_REQ & I_ROTCTRL_WR_ACK & last_pix)
                  | wd_fire;

  assign O_ROTCTRL_BUSY      = (state == S_RD) | (state == S_WR);
  assign O_ROTCTRL_DONE      = done_flag;
  assign O_ROTCTRL_INTR      = done_flag & ~I_ROTCTRL_INTR_MASK;
  assign O_ROTCTRL_DBG_STATE = state;

`ifdef ROTCTRL_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        stalled;
  logic        err_flag;

  assign stalled = (O_ROTCTRL_RD_REQ & ~I_ROTCTRL_RD_ACK) | (O_ROTCTRL_WR_REQ & ~I_ROTCTRL_WR_ACK);
  // Fires on the TIMEOUT_CYC-th consecutive stalled cycle of one request.
  assign wd_fire = stalled & (wd_cnt == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge I_ROTCTRL_HCLK or posedge I_ROTCTRL_HRESET) begin
    if (I_ROTCTRL_HRESET) begin
      wd_cnt <= 32'd0;
    end else if (I_ROTCTRL_SOFT_RESET || !stalled || wd_fire) begin
      wd_cnt <= 32'd0;
    end else begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end

  always_ff @(posedge I_ROTCTRL_HCLK or posedge I_ROTCTRL_HRESET) begin
    if (I_ROTCTRL_HRESET) begin
      err_flag <= 1'b0;
    end else if (I_ROTCTRL_SOFT_RESET || I_ROTCTRL_INTR_CLEAR) begin
      err_flag <= 1'b0;
    end else if (wd_fire) begin
      err_flag <= 1'b1;
    end else if (start_accept) begin
      err_flag <= 1'b0;
    end
  end

  assign O_ROTCTRL_ERR = err_flag;
`else
  assign wd_fire       = 1'b0;
  assign O_ROTCTRL_ERR = 1'b0;
`endif

  always_ff @(posedge I_ROTCTRL_HCLK or posedge I_ROTCTRL_HRESET) begin
    if (I_ROTCTRL_HRESET) begin
      state             <= S_IDLE;
      start_q           <= 1'b0;
      done_flag         <= 1'b0;
      x                 <= 16'd0;
      y                 <= 16'd0;
      cfg_w             <= 16'd0;
      cfg_h             <= 16'd0;
      cfg_src           <= 32'd0;
      cfg_dst           <= 32'd0;
      cfg_rot           <= 2'd0;
      O_ROTCTRL_RD_REQ  <= 1'b0;
      O_ROTCTRL_WR_REQ  <= 1'b0;
      O_ROTCTRL_RD_ADDR <= 32'd0;
      O_ROTCTRL_WR_ADDR <= 32'd0;
      O_ROTCTRL_WR_DATA <= 32'd0;
    end else begin
      start_q <= I_ROTCTRL_START;
      if (I_ROTCTRL_SOFT_RESET) begin
        state             <= S_IDLE;
        done_flag         <= 1'b0;
        x                 <= 16'd0;
        y                 <= 16'd0;
        O_ROTCTRL_RD_REQ  <= 1'b0;
        O_ROTCTRL_WR_REQ  <= 1'b0;
        O_ROTCTRL_RD_ADDR <= 32'd0;
        O_ROTCTRL_WR_ADDR <= 32'd0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_edge) begin
              cfg_src <= I_ROTCTRL_SRC_IMG;
              cfg_dst <= I_ROTCTRL_DST_IMG;
              cfg_w   <= I_ROTCTRL_IMG_W;
              cfg_h   <= I_ROTCTRL_IMG_H;
              cfg_rot <= rot_in;
              x       <= 16'd0;
              y       <= 16'd0;
              if (empty_img) begin
                state <= S_DONE;
              end else begin
                state             <= S_RD;
                O_ROTCTRL_RD_REQ  <= 1'b1;
                O_ROTCTRL_RD_ADDR <= I_ROTCTRL_SRC_IMG;
              end
            end
          end
          S_RD: begin
            if (wd_fire) begin
              O_ROTCTRL_RD_REQ <= 1'b0;
              state            <= S_DONE;
            end else if (I_ROTCTRL_RD_ACK) begin
              O_ROTCTRL_RD_REQ  <= 1'b0;
              O_ROTCTRL_WR_REQ  <= 1'b1;
              O_ROTCTRL_WR_DATA <= I_ROTCTRL_RD_DATA;
              O_ROTCTRL_WR_ADDR <= pix_addr(cfg_dst, dst_index(x, y, cfg_w, cfg_h, cfg_rot));
              state             <= S_WR;
            end
          end
          S_WR: begin
            if (wd_fire) begin
              O_ROTCTRL_WR_REQ <= 1'b0;
              state            <= S_DONE;
            end else if (I_ROTCTRL_WR_ACK) begin
              O_ROTCTRL_WR_REQ <= 1'b0;
              if (last_pix) begin
                state <= S_DONE;
              end else begin
                x                 <= nx;
                y                 <= ny;
                O_ROTCTRL_RD_REQ  <= 1'b1;
                O_ROTCTRL_RD_ADDR <= pix_addr(cfg_src, src_index(nx, ny, cfg_w));
                state             <= S_RD;
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
        endcase

        // Clear beats set; a freshly accepted start drops a stale flag.
        if (I_ROTCTRL_INTR_CLEAR) begin
          done_flag <= 1'b0;
        end else if (done_set) begin
          done_flag <= 1'b1;
        end else if (start_accept) begin
          done_flag <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rot_ctrl.sv
// Directed testbench for rot_ctrl: rotation remap tables, stalls, interrupt flag handling,
// empty images, soft/async reset and the watchdog (or its absence in the default build).
module tb_rot_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] src;
  logic [31:0] dst;
  logic [15:0] img_h;
  logic [15:0] img_w;
  logic [1:0]  mode;
  logic        dir;
  logic        start;
  logic        soft_rst;
  logic        mask;
  logic        clr;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic [15:0] new_h;
  logic [15:0] new_w;
  logic        busy;
  logic        done;
  logic        intr;
  logic        err;
  logic [1:0]  dbg_state;

  int total;
  int bad;

  logic [31:0] obs_rd_q[$];
  logic [31:0] obs_wr_q[$];
  logic [31:0] obs_data_q[$];
  logic [31:0] exp_q[$];
  int          busy_cnt;
  bit          overlap;
  bit          job_to;

  rot_ctrl #(.PIX_SHIFT(2), .TIMEOUT_CYC(16)) dut (
    .I_ROTCTRL_HCLK      (clk),
    .I_ROTCTRL_HRESET    (rst),
    .I_ROTCTRL_SRC_IMG   (src),
    .I_ROTCTRL_DST_IMG   (dst),
    .I_ROTCTRL_IMG_H     (img_h),
    .I_ROTCTRL_IMG_W     (img_w),
    .I_ROTCTRL_IMG_MODE  (mode),
    .I_ROTCTRL_IMG_DIR   (dir),
    .I_ROTCTRL_START     (start),
    .I_ROTCTRL_SOFT_RESET(soft_rst),
    .I_ROTCTRL_INTR_MASK (mask),
    .I_ROTCTRL_INTR_CLEAR(clr),
    .O_ROTCTRL_RD_REQ    (rd_req),
    .O_ROTCTRL_RD_ADDR   (rd_addr),
    .I_ROTCTRL_RD_ACK    (rd_ack),
    .I_ROTCTRL_RD_DATA   (rd_data),
    .O_ROTCTRL_WR_REQ    (wr_req),
    .O_ROTCTRL_WR_ADDR   (wr_addr),
    .O_ROTCTRL_WR_DATA   (wr_data),
    .I_ROTCTRL_WR_ACK    (wr_ack),
    .O_ROTCTRL_NEW_H     (new_h),
    .O_ROTCTRL_NEW_W     (new_w),
    .O_ROTCTRL_BUSY      (busy),
    .O_ROTCTRL_DONE      (done),
    .O_ROTCTRL_INTR      (intr),
    .O_ROTCTRL_ERR       (err),
    .O_ROTCTRL_DBG_STATE (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: raise START, then log every cycle until DONE shows or the budget runs out.
  // The read data driven for each read is pushed to exp_q as the expected write data.
  task automatic run_job(input int budget);
    obs_rd_q.delete();
    obs_wr_q.delete();
    obs_data_q.delete();
    exp_q.delete();
    busy_cnt = 0;
    overlap  = 1'b0;
    job_to   = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_req && wr_req) overlap = 1'b1;
      if (busy) busy_cnt++;
      if (rd_req) begin
        obs_rd_q.push_back(rd_addr);
        rd_data = 32'hD000_0000 + 32'(obs_rd_q.size());
        exp_q.push_back(rd_data);
      end
      if (wr_req) begin
        obs_wr_q.push_back(wr_addr);
        obs_data_q.push_back(wr_data);
      end
      if (done) begin
        job_to = 1'b0;
        break;
      end
    end
  endtask

  task automatic set_cfg(input logic [15:0] w, input logic [15:0] h, input logic [1:0] m,
                         input logic d);
    img_w = w;
    img_h = h;
    mode  = m;
    dir   = d;
    src   = 32'h1000;
    dst   = 32'h2000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({rd_req, wr_req, busy, done, intr, err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=000000", {rd_req, wr_req, busy, done, intr, err});
    end
    total++;
    if ({rd_addr, wr_addr, wr_data} !== 96'd0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_regs got ra=%h wa=%h wd=%h st=%0d exp 0", rd_addr, wr_addr, wr_data,
               dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (dbg_state !== 2'd0 || rd_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got st=%0d rd_req=%b exp st=0 rd_req=0", dbg_state, rd_req);
    end
  endtask

  task automatic test_rotation();
    logic [1:0]  tmode[5];
    logic        tdir[5];
    logic [15:0] enw[5];
    logic [15:0] enh[5];
    logic [31:0] ew[5][6];
    tmode = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd3};
    tdir  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    enw   = '{16'd3, 16'd3, 16'd2, 16'd2, 16'd3};
    enh   = '{16'd2, 16'd2, 16'd3, 16'd3, 16'd2};
    ew    = '{'{32'h2008, 32'h2014, 32'h2004, 32'h2010, 32'h2000, 32'h200C},
              '{32'h200C, 32'h2000, 32'h2010, 32'h2004, 32'h2014, 32'h2008},
              '{32'h2014, 32'h2010, 32'h200C, 32'h2008, 32'h2004, 32'h2000},
              '{32'h2000, 32'h2004, 32'h2008, 32'h200C, 32'h2010, 32'h2014},
              '{32'h2008, 32'h2014, 32'h2004, 32'h2010, 32'h2000, 32'h200C}};
    for (int c = 0; c < 5; c++) begin
      set_cfg(16'd2, 16'd3, tmode[c], tdir[c]);
      rd_ack = 1'b1;
      wr_ack = 1'b1;
      @(negedge clk);
      total++;
      if (new_w !== enw[c] || new_h !== enh[c]) begin
        bad++;
        $display("FAIL rot%0d_dims got w=%0d h=%0d exp w=%0d h=%0d", c, new_w, new_h, enw[c],
                 enh[c]);
      end
      run_job(40);
      total++;
      if (job_to || obs_rd_q.size() != 6 || obs_wr_q.size() != 6) begin
        bad++;
        $display("FAIL rot%0d_count got to=%b rd=%0d wr=%0d exp to=0 rd=6 wr=6", c, job_to,
                 obs_rd_q.size(), obs_wr_q.size());
      end
      for (int i = 0; i < 6 && i < obs_rd_q.size(); i++) begin
        total++;
        if (obs_rd_q[i] !== 32'h1000 + 32'(4 * i)) begin
          bad++;
          $display("FAIL rot%0d_rd[%0d] got=%h exp=%h", c, i, obs_rd_q[i], 32'h1000 + 32'(4 * i));
        end
      end
      for (int i = 0; i < 6 && i < obs_wr_q.size(); i++) begin
        total++;
        if (obs_wr_q[i] !== ew[c][i]) begin
          bad++;
          $display("FAIL rot%0d_wr[%0d] got=%h exp=%h", c, i, obs_wr_q[i], ew[c][i]);
        end
        total++;
        if (i < exp_q.size() && obs_data_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL rot%0d_data[%0d] got=%h exp=%h", c, i, obs_data_q[i], exp_q[i]);
        end
      end
      total++;
      if (busy_cnt != 12 || overlap || done !== 1'b1 || intr !== 1'b1) begin
        bad++;
        $display("FAIL rot%0d_end got busy=%0d ovl=%b done=%b intr=%b exp 12 0 1 1", c,
                 busy_cnt, overlap, done, intr);
      end
    end
  endtask

  task automatic test_ack_stall();
    set_cfg(16'd2, 16'd3, 2'd0, 1'b0);
    rd_ack  = 1'b0;
    wr_ack  = 1'b0;
    rd_data = 32'h0BAD_0000;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if ({rd_req, wr_req} !== 2'b10 || rd_addr !== 32'h1000) begin
        bad++;
        $display("FAIL stall_hold[%0d] got req=%b addr=%h exp req=10 addr=00001000", k,
                 {rd_req, wr_req}, rd_addr);
      end
      if (k == 6) begin
        rd_ack  = 1'b1;
        rd_data = 32'hCAFE_F00D;
      end
    end
    @(negedge clk);
    rd_ack  = 1'b0;
    rd_data = 32'h1234_5678;
    total++;
    if ({rd_req, wr_req} !== 2'b01 || wr_data !== 32'hCAFE_F00D || wr_addr !== 32'h2000) begin
      bad++;
      $display("FAIL stall_capture got req=%b wd=%h wa=%h exp req=01 wd=cafef00d wa=00002000",
               {rd_req, wr_req}, wr_data, wr_addr);
    end
    @(negedge clk);
    total++;
    if (wr_req !== 1'b1 || wr_data !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL stall_wr_hold got wr_req=%b wd=%h exp 1 cafef00d", wr_req, wr_data);
    end
    rd_ack = 1'b1;
    wr_ack = 1'b1;
    for (int c = 0; c < 40 && !done; c++) @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL stall_finish got done=%b exp=1", done);
    end
  endtask

  task automatic test_intr();
    set_cfg(16'd1, 16'd1, 2'd0, 1'b0);
    mask = 1'b1;
    run_job(10);
    total++;
    if (job_to || busy_cnt != 2 || done !== 1'b1 || intr !== 1'b0) begin
      bad++;
      $display("FAIL intr_masked got to=%b busy=%0d done=%b intr=%b exp 0 2 1 0", job_to,
               busy_cnt, done, intr);
    end
    mask = 1'b0;
    #1;
    total++;
    if (intr !== 1'b1) begin
      bad++;
      $display("FAIL intr_unmask got=%b exp=1", intr);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total++;
    if (done !== 1'b0 || intr !== 1'b0) begin
      bad++;
      $display("FAIL intr_clear got done=%b intr=%b exp 0 0", done, intr);
    end
    // Clear held through the final write: the clear must win over the set.
    clr = 1'b1;
    run_job(6);
    clr = 1'b0;
    total++;
    if (!job_to || busy_cnt != 2 || done !== 1'b0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL intr_clear_wins got to=%b busy=%0d done=%b st=%0d exp 1 2 0 0", job_to,
               busy_cnt, done, dbg_state);
    end
  endtask

  task automatic test_zero_dim();
    set_cfg(16'd4, 16'd0, 2'd0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b1 || {rd_req, wr_req, busy} !== 3'b0 || dbg_state !== 2'd3) begin
      bad++;
      $display("FAIL zero_h got done=%b req=%b busy=%b st=%0d exp 1 00 0 3", done,
               {rd_req, wr_req}, busy, dbg_state);
    end
    @(negedge clk);
    total++;
    if (dbg_state !== 2'd0 || done !== 1'b1 || rd_req !== 1'b0) begin
      bad++;
      $display("FAIL zero_h_idle got st=%0d done=%b rd_req=%b exp 0 1 0", dbg_state, done, rd_req);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    set_cfg(16'd0, 16'd5, 2'd1, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b1 || {rd_req, wr_req, busy} !== 3'b0) begin
      bad++;
      $display("FAIL zero_w got done=%b req=%b busy=%b exp 1 00 0", done, {rd_req, wr_req}, busy);
    end
  endtask

  task automatic test_soft_reset();
    set_cfg(16'd2, 16'd3, 2'd0, 1'b0);
    rd_ack = 1'b1;
    wr_ack = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    total++;
    if (wr_req !== 1'b1 || dbg_state !== 2'd2 || wr_addr !== 32'h2004) begin
      bad++;
      $display("FAIL sreset_pre got wr_req=%b st=%0d wa=%h exp 1 2 00002004", wr_req, dbg_state,
               wr_addr);
    end
    soft_rst = 1'b1;
    @(negedge clk);
    soft_rst = 1'b0;
    total++;
    if (dbg_state !== 2'd0 || {rd_req, wr_req, busy, done} !== 4'b0) begin
      bad++;
      $display("FAIL sreset_abort got st=%0d req=%b busy=%b done=%b exp 0 00 0 0", dbg_state,
               {rd_req, wr_req}, busy, done);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (rd_req !== 1'b1 || rd_addr !== 32'h1000) begin
      bad++;
      $display("FAIL sreset_restart got rd_req=%b ra=%h exp 1 00001000", rd_req, rd_addr);
    end
    @(negedge clk);
    total++;
    if (wr_req !== 1'b1 || wr_addr !== 32'h2000) begin
      bad++;
      $display("FAIL sreset_first_wr got wr_req=%b wa=%h exp 1 00002000", wr_req, wr_addr);
    end
    for (int c = 0; c < 40 && !done; c++) @(negedge clk);
    // Soft reset and a start edge in the same cycle: soft reset wins.
    start    = 1'b1;
    soft_rst = 1'b1;
    @(negedge clk);
    soft_rst = 1'b0;
    total++;
    if (dbg_state !== 2'd0 || rd_req !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL sreset_vs_start got st=%0d rd_req=%b done=%b exp 0 0 0", dbg_state, rd_req,
               done);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_busy_start();
    set_cfg(16'd2, 16'd3, 2'd0, 1'b0);
    busy_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (k == 2) start = 1'b0;
      if (k == 3) start = 1'b1;
      if (k == 5) begin
        total++;
        if (rd_req !== 1'b1 || rd_addr !== 32'h1008) begin
          bad++;
          $display("FAIL busy_start_addr got rd_req=%b ra=%h exp 1 00001008", rd_req, rd_addr);
        end
      end
      if (done) break;
    end
    start = 1'b0;
    total++;
    if (busy_cnt != 12 || done !== 1'b1) begin
      bad++;
      $display("FAIL busy_start_len got busy=%0d done=%b exp 12 1", busy_cnt, done);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    set_cfg(16'd2, 16'd3, 2'd0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({rd_req, wr_req, busy} !== 3'b0) begin
      bad++;
      $display("FAIL async_reset got req=%b busy=%b exp 00 0", {rd_req, wr_req}, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_watchdog();
    set_cfg(16'd2, 16'd3, 2'd0, 1'b0);
    rd_ack = 1'b0;
    @(negedge clk);
    start = 1'b1;
`ifdef ROTCTRL_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    total++;
    if (rd_req !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL wd_before got rd_req=%b err=%b exp 1 0", rd_req, err);
    end
    @(negedge clk);
    total++;
    if (rd_req !== 1'b0 || err !== 1'b1 || done !== 1'b1) begin
      bad++;
      $display("FAIL wd_fire got rd_req=%b err=%b done=%b exp 0 1 1", rd_req, err, done);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total++;
    if (err !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL wd_clear got err=%b done=%b exp 0 0", err, done);
    end
`else
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    total++;
    if (rd_req !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL wd_absent got rd_req=%b busy=%b err=%b exp 1 1 0", rd_req, busy, err);
    end
    soft_rst = 1'b1;
    @(negedge clk);
    soft_rst = 1'b0;
`endif
    rd_ack = 1'b1;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    src      = 32'd0;
    dst      = 32'd0;
    img_h    = 16'd0;
    img_w    = 16'd0;
    mode     = 2'd0;
    dir      = 1'b0;
    start    = 1'b0;
    soft_rst = 1'b0;
    mask     = 1'b0;
    clr      = 1'b0;
    rd_ack   = 1'b1;
    wr_ack   = 1'b1;
    rd_data  = 32'd0;

    test_reset();
    test_rotation();
    test_ack_stall();
    test_intr();
    test_zero_dim();
    test_soft_reset();
    test_busy_start();
    test_async_reset();
    test_watchdog();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
